apb_i2c_fifo: RTL and testbench

APB_I2C_FIFO -- requirements
Module: apb_i2c_fifo

---
 rtl/apb_i2c_pkg.sv | 13 +
 rtl/apb_i2c_fifo_if.sv | 28 ++
 rtl/apb_i2c_fifo_mem.sv | 26 ++
 rtl/apb_i2c_fifo.sv | 93 +++++++++
 tb/tb_apb_i2c_fifo.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/apb_i2c_pkg.sv
// Shared sizing defaults for the APB slave, I2C core and their data FIFO.
package apb_i2c_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    localparam int FIFO_DEPTH = fifo_depth(DEF_ADDR_WIDTH);

endpackage

// File: rtl/apb_i2c_fifo_if.sv
// Push/pop bus between the APB slave (master side) and the FIFO (slave side).
interface apb_i2c_fifo_if
    import apb_i2c_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  WR_ENA;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  RD_ENA;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  FULL;
    logic                  EMPTY;
    logic [ADDR_WIDTH:0]   COUNT;
    logic                  ERR_CLR;
    logic                  ERROR;

    modport master (
        output WR_ENA, WR_DATA, RD_ENA, ERR_CLR,
        input  RD_DATA, FULL, EMPTY, COUNT, ERROR
    );

    modport slave (
        input  WR_ENA, WR_DATA, RD_ENA, ERR_CLR,
        output RD_DATA, FULL, EMPTY, COUNT, ERROR
    );

endinterface

// File: rtl/apb_i2c_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module apb_i2c_fifo_mem
    import apb_i2c_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_i2c_fifo.sv
// First-word fall-through FIFO between the APB slave and the I2C core.
// Sticky ERROR flag is built only when APB_I2C_FIFO_ERROR_EN is defined.
module apb_i2c_fifo
    import apb_i2c_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic           PCLK,
    input  logic           PRESET,
    apb_i2c_fifo_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(fifo_depth(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    assign full  = (count == DEPTH);
    assign empty = (count == '0);
    assign pop   = bus.RD_ENA && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same edge.
    assign push  = bus.WR_ENA && (!full || bus.RD_ENA);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    apb_i2c_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (PCLK),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.WR_DATA),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign bus.RD_DATA = empty ? '0 : head;
    assign bus.FULL    = full;
    assign bus.EMPTY   = empty;
    assign bus.COUNT   = count;

`ifdef APB_I2C_FIFO_ERROR_EN
    logic error;
    logic err_set;

    assign err_set = (bus.WR_ENA && full && !bus.RD_ENA) || (bus.RD_ENA && empty);

    // A new fault outranks a clear arriving in the same cycle.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            error <= 1'b0;
        end else if (err_set) begin
            error <= 1'b1;
        end else if (bus.ERR_CLR) begin
            error <= 1'b0;
        end
    end

    assign bus.ERROR = error;
`else
    logic err_clr_unused;

    assign err_clr_unused = bus.ERR_CLR;
    assign bus.ERROR      = 1'b0;
`endif

endmodule

// File: tb/tb_apb_i2c_fifo.sv
// Bench for apb_i2c_fifo: directed scenarios plus random traffic against a queue model.
module tb_apb_i2c_fifo;
    import apb_i2c_pkg::*;

`ifdef APB_I2C_FIFO_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_i2c_fifo_if bus ();

    apb_i2c_fifo dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    logic [31:0] q[$];
    bit          m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: a plain queue of words and a sticky bit, advanced on every rising edge.
    always @(posedge clk) begin
        bit m_full, m_empty, do_pop, do_push, set;
        if (rst) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            m_full  = (q.size() == FIFO_DEPTH);
            m_empty = (q.size() == 0);
            do_pop  = bus.RD_ENA && !m_empty;
            do_push = bus.WR_ENA && (!m_full || bus.RD_ENA);
            set     = (bus.WR_ENA && m_full && !bus.RD_ENA) || (bus.RD_ENA && m_empty);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(bus.WR_DATA);
            if (ERR_EN) begin
                if (set) m_err = 1'b1;
                else if (bus.ERR_CLR) m_err = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("count", 32'(bus.COUNT), 32'(q.size()));
            check("empty", 32'(bus.EMPTY), 32'(q.size() == 0));
            check("full", 32'(bus.FULL), 32'(q.size() == FIFO_DEPTH));
            check("rd_data", bus.RD_DATA, (q.size() == 0) ? 32'h0 : q[0]);
            check("error", 32'(bus.ERROR), 32'(m_err));
        end
    end

    task automatic step(input bit w, input logic [31:0] d, input bit r, input bit c, input bit p);
        bus.WR_ENA  = w;
        bus.WR_DATA = d;
        bus.RD_ENA  = r;
        bus.ERR_CLR = c;
        rst         = p;
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        bus.WR_ENA  = 1'b0;
        bus.WR_DATA = '0;
        bus.RD_ENA  = 1'b0;
        bus.ERR_CLR = 1'b0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        checking = 1'b1;
        settle();
        check("rst_count", 32'(bus.COUNT), 0);
        check("rst_empty", 32'(bus.EMPTY), 1);
        check("rst_full", 32'(bus.FULL), 0);
        check("rst_rd_data", bus.RD_DATA, 0);
        check("rst_error", 32'(bus.ERROR), 0);

        step(1, 32'hA5A5_0001, 0, 0, 0);
        settle();
        check("first_rd_data", bus.RD_DATA, 32'hA5A5_0001);
        check("first_empty", 32'(bus.EMPTY), 0);
        check("first_count", 32'(bus.COUNT), 1);
        step(0, 0, 1, 0, 0);

        for (int i = 0; i < 32; i++) step(1, 32'(i), 0, 0, 0);
        settle();
        check("fill_full", 32'(bus.FULL), 1);
        check("fill_count", 32'(bus.COUNT), 32);
        step(1, 32'hDEAD, 0, 0, 0);
        settle();
        check("ovf_count", 32'(bus.COUNT), 32);
        check("ovf_error", 32'(bus.ERROR), 32'(ERR_EN));
        check("ovf_head", bus.RD_DATA, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 32; i++) begin
            settle();
            check("pop_order", bus.RD_DATA, 32'(i));
            step(0, 0, 1, 0, 0);
        end
        settle();
        check("drained_empty", 32'(bus.EMPTY), 1);

        for (int i = 0; i < 32; i++) step(1, 32'(100 + i), 0, 0, 0);
        step(1, 32'h77, 1, 0, 0);
        settle();
        check("full_rw_count", 32'(bus.COUNT), 32);
        check("full_rw_error", 32'(bus.ERROR), 0);
        check("full_rw_head", bus.RD_DATA, 32'd101);
        for (int i = 0; i < 31; i++) step(0, 0, 1, 0, 0);
        settle();
        check("full_rw_last", bus.RD_DATA, 32'h77);
        step(0, 0, 1, 0, 0);

        step(1, 32'h55, 1, 0, 0);
        settle();
        check("empty_rw_count", 32'(bus.COUNT), 1);
        check("empty_rw_data", bus.RD_DATA, 32'h55);
        check("empty_rw_error", 32'(bus.ERROR), 32'(ERR_EN));
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        settle();
        check("set_wins", 32'(bus.ERROR), 32'(ERR_EN));
        step(0, 0, 0, 1, 0);
        settle();
        check("clr_error", 32'(bus.ERROR), 0);

        for (int i = 0; i < 3; i++) step(1, 32'(200 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            settle();
            check("wrap_order", bus.RD_DATA, 32'(200 + i));
            step(1, 32'(203 + i), 1, 0, 0);
        end
        settle();
        check("wrap_count", 32'(bus.COUNT), 3);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 32'(300 + i), 0, 0, 0);
        settle();
        check("pre_rst_count", 32'(bus.COUNT), 10);
        check("pre_rst_error", 32'(bus.ERROR), 32'(ERR_EN));
        step(1, 32'h99, 0, 1, 1);
        settle();
        check("mid_rst_count", 32'(bus.COUNT), 0);
        check("mid_rst_empty", 32'(bus.EMPTY), 1);
        check("mid_rst_rd_data", bus.RD_DATA, 0);
        check("mid_rst_error", 32'(bus.ERROR), 0);

        for (int i = 0; i < 3000; i++) begin
            int phase, p_wr, p_rd;
            phase = (i / 250) % 3;
            p_wr  = (phase == 0) ? 80 : (phase == 1) ? 30 : 60;
            p_rd  = (phase == 0) ? 30 : (phase == 1) ? 80 : 60;
            step($urandom_range(0, 99) < p_wr, $urandom, $urandom_range(0, 99) < p_rd,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 499) == 0);
        end
        step(0, 0, 0, 0, 0);
        settle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
